// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes and FSM states.
package muldiv_unit_pkg;

  localparam int MULDIV_OP_W = 3;

  typedef enum logic [MULDIV_OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MULDIV_S_IDLE = 2'd0,
    MULDIV_S_RUN  = 2'd1,
    MULDIV_S_FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: shift/add multiply or restoring divide on a {upper, lower} accumulator.
module muldiv_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Divide keeps {remainder, dividend/quotient}; a clear top bit of the trial means no borrow.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_opnd};
    o_qbit  = 1'b0;
    o_acc   = {w_sum, i_acc[WIDTH-1:1]};
    if (i_is_div) begin
      o_qbit = ~w_trial[WIDTH];
      o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], o_qbit};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair; one start per operation, WIDTH+1 cycles busy.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  muldiv_state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_div0;

  logic               w_accept, w_fix, w_mt_hi, w_mt_lo;
  logic               w_signed_op, w_is_div_op, w_a_neg, w_b_neg;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_hi_fix, w_lo_fix;

  assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign w_a_s       = a;
  assign w_b_s       = b;
  assign w_a_neg     = w_signed_op && (w_a_s < 0);
  assign w_b_neg     = w_signed_op && (w_b_s < 0);
  assign w_mag_a     = neg_if(a, w_a_neg);
  assign w_mag_b     = neg_if(b, w_b_neg);

  muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_nxt),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= MULDIV_S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fix       = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    case (r_state)
      MULDIV_S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              w_accept    = 1'b1;
              w_state_nxt = MULDIV_S_RUN;
            end
            OP_MTHI: w_mt_hi = 1'b1;
            OP_MTLO: w_mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MULDIV_S_RUN: begin
        if (cancel)                           w_state_nxt = MULDIV_S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))  w_state_nxt = MULDIV_S_FIX;
      end
      MULDIV_S_FIX: begin
        w_fix       = !cancel;
        w_state_nxt = MULDIV_S_IDLE;
      end
      default: w_state_nxt = MULDIV_S_IDLE;
    endcase
  end

  // Sign fix-up: product/quotient negate on differing signs, remainder follows the dividend.
  always_comb begin
    w_prod   = neg2_if(r_acc, r_neg_q);
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_hi_fix = neg_if(r_acc[2*WIDTH-1:WIDTH], r_neg_r);
      w_lo_fix = r_dz ? '1 : neg_if(r_acc[WIDTH-1:0], r_neg_q);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= w_is_div_op;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_dz     <= w_is_div_op && (b == '0);
      end else if (r_state == MULDIV_S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_mt_hi) r_hi <= a;
      if (w_mt_lo) r_lo <= a;
      if (w_fix) begin
        r_hi   <= w_hi_fix;
        r_lo   <= w_lo_fix;
        r_done <= 1'b1;
        r_div0 <= r_is_div && r_dz;
      end
    end
  end

  // Multiply starts as {0, multiplier}; divide as {0, dividend}. The step operand is the other magnitude.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc  <= {{WIDTH{1'b0}}, (w_is_div_op ? w_mag_a : w_mag_b)};
      r_opnd <= w_is_div_op ? w_mag_b : w_mag_a;
    end else if (r_state == MULDIV_S_RUN) begin
      r_acc  <= w_acc_nxt;
    end
  end

  assign busy = (r_state != MULDIV_S_IDLE);
  assign done = r_done;
  assign div0 = r_div0;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand sequences for MTHI/MTLO, cancel and async reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t tv[9];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .res    (res),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .div0   (div0),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_done(output int n, output int bad_busy);
    n = 0;
    bad_busy = 0;
    while (!done && n < 100) begin
      if (!busy) bad_busy++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bb, dcnt;

    tv[0] = '{3'(OP_MULT),  32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    tv[1] = '{3'(OP_DIV),   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tv[2] = '{3'(OP_DIVU),  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
    tv[3] = '{3'(OP_DIVU),  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    tv[4] = '{3'(OP_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tv[5] = '{3'(OP_DIV),   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    tv[6] = '{3'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tv[7] = '{3'(OP_MULT),  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tv[8] = '{3'(OP_DIV),   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_div0", 64'(div0), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    res = 1'b0;

    issue(3'(OP_MTLO), 32'h0000_00AA, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'h0000_00AA);
    chk("mtlo_hi", 64'(hi), 64'h0);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    issue(3'(OP_MTHI), 32'h0000_0055, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h0000_0055);
    chk("mthi_lo", 64'(lo), 64'h0000_00AA);

    for (int i = 0; i < 9; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b);
      wait_done(n, bb);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'd33);
      chk($sformatf("v%0d_busy_hold", i), 64'(bb), 64'd0);
      chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(tv[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(tv[i].lo));
      chk($sformatf("v%0d_div0", i), 64'(div0), 64'(tv[i].dz));
      @(negedge clk);
      chk($sformatf("v%0d_done_drop", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_div0_drop", i), 64'(div0), 64'd0);
    end

    // MTHI while busy must be ignored; the multiply then lands normally.
    issue(3'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'(OP_MTHI); a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    chk("mthi_busy_hi", 64'(hi), 64'(tv[8].hi));
    wait_done(n, bb);
    chk("mthi_busy_latency", 64'(n), 64'd29);
    chk("mthi_busy_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Cancel ten cycles into a MULT.
    issue(3'(OP_MULT), 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("cancel_pre_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("cancel_no_done", 64'(dcnt), 64'd0);
    chk("cancel_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Cancel together with start in IDLE wins.
    start = 1'b1; cancel = 1'b1; op = 3'(OP_MULT); a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 3'd0;
    chk("cancel_start_busy", 64'(busy), 64'd0);
    start = 1'b1; cancel = 1'b1; op = 3'(OP_MTLO); a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 3'd0;
    chk("cancel_mtlo_lo", 64'(lo), 64'h0000_0001);

    // Asynchronous reset mid-DIV, away from a clock edge.
    issue(3'(OP_DIV), 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 res = 1'b1;
    #1;
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_done", 64'(done), 64'd0);
    chk("areset_div0", 64'(div0), 64'd0);
    chk("areset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    res = 1'b0;
    issue(3'(OP_MULTU), 32'd3, 32'd5);
    wait_done(n, bb);
    chk("post_reset_latency", 64'(n), 64'd33);
    chk("post_reset_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit holding the HI/LO accumulator pair for the CPU core.
- Accepts one operation per start pulse from the core's EXEC state.
- Runs a radix-2 shift/add or restoring-divide sequence over WIDTH cycles, then writes HI/LO.
- The core stalls on busy before MFHI/MFLO or any further mul/div operation. An exception or eret can cancel an operation in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 2.
CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
clk  in  1  clock, rising-edge active
res  in  1  asynchronous active-high reset
start  in  1  sample op/a/b this cycle; honoured only when busy=0
op  in  3  `MULDIV_OP_T: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
b  in  WIDTH  rt operand (multiplier / divisor)
cancel  in  1  abort the current operation; HI/LO keep their pre-start values
busy  out  1  operation in progress; core must stall MFHI/MFLO/mul/div
done  out  1  one-cycle pulse; the cycle in which new HI/LO are first visible
div0  out  1  qualified by done; the last DIV/DIVU had divisor 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; hi, lo, busy, done, div0 all 0; counter 0.
- FSM states IDLE, RUN, FIX.
- IDLE:
  - start with MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops use two's-complement absolute value; |MIN| is representable as unsigned WIDTH bits); latch result sign flags; go to RUN; counter=0.
  - start with MTHI/MTLO: hi<=a or lo<=a at that edge; stay IDLE; no done pulse.
  - op=NONE: ignored.
- RUN: one iteration per cycle; counter increments. After WIDTH iterations, go to FIX.
  - Multiply: 2*WIDTH-bit shift/add on magnitudes.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply sign fix-up; write hi/lo; go to IDLE; done=1 and busy=0 in the following cycle.
- Latency: start sampled at edge k; busy=1 after edge k through edge k+WIDTH+1; done=1 for exactly the cycle after edge k+WIDTH+1.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. For signed, negate when the signs of a and b differ.
- DIV/DIVU:
  - lo = quotient, truncated toward zero; negative when signs differ.
  - hi = remainder, taking the sign of the dividend.
  - Signed MIN / -1: lo=MIN, hi=0, no flag.
- Divisor 0 (DIV or DIVU): lo = all ones, hi = a; div0=1 with done. The unit still takes the full latency.
- start while busy: ignored. No queueing and no error; the core guarantees a stall.
- cancel:
  - In RUN or FIX: go to IDLE at the next edge; hi/lo untouched; no done pulse.
  - In IDLE: start is ignored that cycle (cancel wins over a simultaneous start).
- done and div0 are registered; they deassert the cycle after the pulse.
- hi/lo are registered outputs that change only at a FIX edge or an MTHI/MTLO edge.

Decomposition:
- Shared header muldiv.vh, beside ALUOp.vh and CPU.vh: `MULDIV_OP_T width macro; the op-code constants above; state encodings MULDIV_S_IDLE/RUN/FIX.
- One sub-module, muldiv_step (combinational): given mode, partial remainder/product, and operand magnitudes, produces the next partial value and the quotient bit. The top level holds the FSM, counter, sign flags and HI/LO.

Test Plan (all with WIDTH=32):
1. MULT a=7, b=0xFFFFFFFA (-6), start at edge 0 -> busy edges 1..33; done in the cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFD6.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
3. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div0=1 with done. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
4. MTLO a=0xAA, then MULTU 0xFFFFFFFF*0xFFFFFFFF -> after the MTLO edge lo=0xAA; after the multiply hi=0xFFFFFFFE, lo=0x00000001. MTHI issued while busy -> hi unchanged.
5. cancel asserted 10 cycles into a MULT -> busy drops after the next edge; no done; hi/lo retain prior values. cancel together with start in IDLE -> no operation begins.
6. res pulsed asynchronously mid-DIV, away from a clock edge -> busy, done, div0, hi, lo go to 0 immediately. A fresh MULTU 3*5 then gives hi=0, lo=15.
